button_event_arbiter: RTL and testbench

BUTTON_EVENT_ARBITER -- requirements
Module: button_event_arbiter

---
 rtl/button_event_arbiter.sv | 143 ++++++++++++++
 tb/tb_button_event_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | button_event_arbiter: debounces NUM_BUTTONS raw buttons and offers press   |
// | events one at a time over a valid/ready port, round-robin among pending.   |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module button_event_arbiter #(
  parameter int NUM_BUTTONS = 4,
  parameter int IDX_W       = 2,
  parameter int SAMPLE_DIV  = 1000000,
  parameter int DIV_BITS    = 21
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_BUTTONS-1:0] btn_raw,
  input  logic                   evt_ready,
  output logic                   evt_valid,
  output logic [IDX_W-1:0]       evt_code,
  output logic [NUM_BUTTONS-1:0] btn_level,
  output logic                   drop_pulse
);

  localparam logic [0:0]          S_IDLE    = 1'b0;
  localparam logic [0:0]          S_OFFER   = 1'b1;
  localparam logic [DIV_BITS-1:0] DIV_LAST  = DIV_BITS'(SAMPLE_DIV - 1);
  localparam logic [IDX_W-1:0]    LAST_INIT = IDX_W'(NUM_BUTTONS - 1);

  logic [NUM_BUTTONS-1:0] sync1_q, sync2_q;
  logic [DIV_BITS-1:0]    cnt_q, cnt_d;
  logic                   tick, tick_q;
  logic [NUM_BUTTONS-1:0] hist0_q, hist1_q;
  logic [NUM_BUTTONS-1:0] level_q, level_d, hist_eq;
  logic [NUM_BUTTONS-1:0] pending_q, pending_d;
  logic [NUM_BUTTONS-1:0] press, clr, merge;
  logic [0:0]             state_q, state_d;
  logic                   valid_q, valid_d;
  logic [IDX_W-1:0]       code_q, code_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic                   drop_q, drop_d;
  logic [IDX_W-1:0]       sel;
  logic                   found;
  logic                   accept;

  assign tick  = (cnt_q == DIV_LAST);
  assign cnt_d = tick ? '0 : cnt_q + DIV_BITS'(1);

  // Level follows the history only when the two samples agree; tick_q delays this by one cycle.
  assign hist_eq = ~(hist0_q ^ hist1_q);
  assign level_d = tick_q ? ((hist0_q & hist_eq) | (level_q & ~hist_eq)) : level_q;
  assign press   = level_d & ~level_q;

  assign accept    = valid_q & evt_ready;
  assign clr       = accept ? (NUM_BUTTONS'(1) << code_q) : '0;
  assign merge     = press & pending_q & ~clr;
  assign drop_d    = |merge;
  assign pending_d = (pending_q & ~clr) | press;

  // Round-robin: first pending index above last, otherwise wrap to the lowest pending index.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      if (!found && pending_q[i] && (i > int'(last_q))) begin
        sel   = IDX_W'(i);
        found = 1'b1;
      end
    end
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      if (!found && pending_q[i]) begin
        sel   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    code_d  = code_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE: begin
        if (|pending_q) begin
          code_d  = sel;
          valid_d = 1'b1;
          state_d = S_OFFER;
        end
      end
      S_OFFER: begin
        if (accept) begin
          valid_d = 1'b0;
          last_d  = code_q;
          state_d = S_IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      cnt_q     <= '0;
      tick_q    <= 1'b0;
      hist0_q   <= '0;
      hist1_q   <= '0;
      level_q   <= '0;
      pending_q <= '0;
      state_q   <= S_IDLE;
      valid_q   <= 1'b0;
      code_q    <= '0;
      last_q    <= LAST_INIT;
      drop_q    <= 1'b0;
    end else begin
      sync1_q   <= btn_raw;
      sync2_q   <= sync1_q;
      cnt_q     <= cnt_d;
      tick_q    <= tick;
      if (tick) begin
        hist0_q <= sync2_q;
        hist1_q <= hist0_q;
      end
      level_q   <= level_d;
      pending_q <= pending_d;
      state_q   <= state_d;
      valid_q   <= valid_d;
      code_q    <= code_d;
      last_q    <= last_d;
      drop_q    <= drop_d;
    end
  end

  assign evt_valid  = valid_q;
  assign evt_code   = code_q;
  assign btn_level  = level_q;
  assign drop_pulse = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_button_event_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_button_event_arbiter: directed checks of debounce, arbitration, merge    |
// | and reset behaviour with SAMPLE_DIV=4, NUM_BUTTONS=4.                       |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module tb_button_event_arbiter;
  localparam int NB = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NB-1:0] btn_raw = '0;
  logic          evt_ready = 1'b0;
  logic          evt_valid;
  logic [IW-1:0] evt_code;
  logic [NB-1:0] btn_level;
  logic          drop_pulse;

  int n_total = 0;
  int n_bad   = 0;
  int codes[$];
  int drop_cnt = 0, b2b_cnt = 0, unstable_cnt = 0;
  logic prev_valid = 1'b0, prev_ready = 1'b0;
  logic [IW-1:0] prev_code = '0;

  button_event_arbiter #(.NUM_BUTTONS(NB), .IDX_W(IW), .SAMPLE_DIV(4), .DIV_BITS(2)) dut (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .evt_ready(evt_ready),
    .evt_valid(evt_valid), .evt_code(evt_code), .btn_level(btn_level), .drop_pulse(drop_pulse)
  );

  always #5 clk = ~clk;

  // Observer: logs accepted codes, drop pulses, back-to-back valids and unstable offers.
  always @(negedge clk) begin
    if (rst_n) begin
      if (evt_valid && evt_ready) codes.push_back(int'(evt_code));
      if (drop_pulse) drop_cnt++;
      if (evt_valid && prev_valid && prev_ready) b2b_cnt++;
      if (prev_valid && !prev_ready && (!evt_valid || evt_code != prev_code)) unstable_cnt++;
    end
    prev_valid = evt_valid & rst_n;
    prev_ready = evt_ready;
    prev_code  = evt_code;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    btn_raw   = '0;
    evt_ready = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    codes.delete();
    drop_cnt = 0;
    b2b_cnt = 0;
    unstable_cnt = 0;
  endtask

  task automatic wait_valid(input int budget, input string tag);
    int n = 0;
    while (!evt_valid && n < budget) begin
      step();
      n++;
    end
    chk(tag, 32'(evt_valid), 32'd1);
  endtask

  task automatic wait_level(input int idx, input logic val, input int budget, input string tag);
    int n = 0;
    while (btn_level[idx] !== val && n < budget) begin
      step();
      n++;
    end
    chk(tag, 32'(btn_level[idx]), 32'(val));
  endtask

  task automatic wait_codes(input int num, input int budget, input string tag);
    int n = 0;
    while (codes.size() < num && n < budget) begin
      step();
      n++;
    end
    chk(tag, 32'(codes.size()), 32'(num));
  endtask

  function automatic int code_at(input int i);
    return (i < codes.size()) ? codes[i] : -1;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // Reset values while rst_n is held low
    rst_n = 1'b0;
    repeat (2) step();
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_code", 32'(evt_code), 32'd0);
    chk("rst_level", 32'(btn_level), 32'd0);
    chk("rst_drop", 32'(drop_pulse), 32'd0);

    // Bounce on button 1: odd-cycle values are the ones the tick samples, and they stay 0
    do_reset();
    evt_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      btn_raw[1] = (i % 2 == 0);
      step();
    end
    btn_raw[1] = 1'b1;
    chk("bounce_no_evt", 32'(codes.size()), 32'd0);
    chk("bounce_level_lo", 32'(btn_level), 32'd0);
    wait_level(1, 1'b1, 15, "bounce_level_rise");
    wait_codes(1, 10, "bounce_evt");
    repeat (10) step();
    chk("bounce_one_evt", 32'(codes.size()), 32'd1);
    chk("bounce_code", 32'(code_at(0)), 32'd1);
    btn_raw = '0;
    wait_level(1, 1'b0, 20, "bounce_level_fall");
    repeat (5) step();
    chk("release_no_evt", 32'(codes.size()), 32'd1);

    // Simultaneous presses on 0, 1, 3
    do_reset();
    evt_ready = 1'b1;
    btn_raw = 4'b1011;
    wait_codes(3, 40, "simul_evts");
    repeat (5) step();
    chk("simul_count", 32'(codes.size()), 32'd3);
    chk("simul_c0", 32'(code_at(0)), 32'd0);
    chk("simul_c1", 32'(code_at(1)), 32'd1);
    chk("simul_c2", 32'(code_at(2)), 32'd3);
    chk("simul_b2b", 32'(b2b_cnt), 32'd0);

    // Backpressure on button 2
    do_reset();
    btn_raw = 4'b0100;
    wait_valid(40, "bp_valid");
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid_hold", 32'(evt_valid), 32'd1);
      chk("bp_code_hold", 32'(evt_code), 32'd2);
      step();
    end
    evt_ready = 1'b1;
    step();
    chk("bp_valid_drop", 32'(evt_valid), 32'd0);
    chk("bp_pend_clr", 32'(dut.pending_q[2]), 32'd0);
    repeat (10) step();
    chk("bp_count", 32'(codes.size()), 32'd1);
    chk("bp_code", 32'(code_at(0)), 32'd2);
    chk("bp_stable", 32'(unstable_cnt), 32'd0);

    // Merge: button 0 re-pressed while its event is held
    do_reset();
    btn_raw = 4'b0001;
    wait_valid(40, "merge_valid");
    chk("merge_code", 32'(evt_code), 32'd0);
    btn_raw = 4'b0000;
    wait_level(0, 1'b0, 30, "merge_fall");
    btn_raw = 4'b0001;
    wait_level(0, 1'b1, 30, "merge_rise");
    repeat (3) step();
    chk("merge_drop", 32'(drop_cnt), 32'd1);
    chk("merge_hold_code", 32'(evt_code), 32'd0);
    evt_ready = 1'b1;
    repeat (10) step();
    chk("merge_count", 32'(codes.size()), 32'd1);
    chk("merge_evt_code", 32'(code_at(0)), 32'd0);
    chk("merge_stable", 32'(unstable_cnt), 32'd0);

    // Fairness: buttons 0 and 3 pressed repeatedly
    do_reset();
    evt_ready = 1'b1;
    for (int r = 0; r < 2; r++) begin
      btn_raw = 4'b1001;
      wait_codes(2 * r + 2, 40, "fair_evts");
      btn_raw = 4'b0000;
      repeat (20) step();
    end
    chk("fair_c0", 32'(code_at(0)), 32'd0);
    chk("fair_c1", 32'(code_at(1)), 32'd3);
    chk("fair_c2", 32'(code_at(2)), 32'd0);
    chk("fair_c3", 32'(code_at(3)), 32'd3);

    // Reset asserted while an event is offered
    do_reset();
    btn_raw = 4'b0010;
    wait_valid(40, "rmo_valid");
    rst_n = 1'b0;
    #1;
    chk("rmo_valid", 32'(evt_valid), 32'd0);
    chk("rmo_code", 32'(evt_code), 32'd0);
    chk("rmo_level", 32'(btn_level), 32'd0);
    chk("rmo_drop", 32'(drop_pulse), 32'd0);
    btn_raw = '0;
    repeat (3) step();
    rst_n = 1'b1;
    codes.delete();
    evt_ready = 1'b1;
    repeat (40) step();
    chk("rmo_no_evt", 32'(codes.size()), 32'd0);
    btn_raw = 4'b0010;
    wait_codes(1, 40, "rmo_fresh");
    chk("rmo_fresh_code", 32'(code_at(0)), 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
